// File: rtl/dstack_ctrl_if.sv
// ---------------------------------------------------------------------------
// dstack_ctrl_if
// Bundles every non-clock signal of the dstack sequencer into one interface:
// the decode-side op handshake, the fault report/acknowledge pair and the
// dstack control/readback lines.
//   master : the environment (decode stage + dstack) that issues ops, acks
//            faults and returns the dstack top/second/third/rot_val words
//   slave  : the dstack_ctrl sequencer itself
// Signals
//   op_valid/op_ready/op_code/op_n/op_data   op request handshake
//   stk_top/stk_second/stk_third/stk_rot_val dstack readback words
//   movement/rotate/rot_addr/next_top        dstack command lines
//   depth                                    committed element count
//   fault/fault_code/fault_ack               fault report and acknowledge
//   stk_reset                                dstack depth-clear request
// ---------------------------------------------------------------------------
interface dstack_ctrl_if #(
    parameter int DEPTH_MAG = 7,
    parameter int WIDTH     = 32
) ();

    logic                 op_valid;
    logic                 op_ready;
    logic [2:0]           op_code;
    logic [5:0]           op_n;
    logic [WIDTH-1:0]     op_data;
    logic [WIDTH-1:0]     stk_top;
    logic [WIDTH-1:0]     stk_second;
    logic [WIDTH-1:0]     stk_third;
    logic [WIDTH-1:0]     stk_rot_val;
    logic [1:0]           movement;
    logic                 rotate;
    logic [5:0]           rot_addr;
    logic [WIDTH-1:0]     next_top;
    logic [DEPTH_MAG:0]   depth;
    logic                 fault;
    logic [1:0]           fault_code;
    logic                 fault_ack;
    logic                 stk_reset;

    modport master (
        output op_valid, op_code, op_n, op_data,
        output stk_top, stk_second, stk_third, stk_rot_val,
        output fault_ack,
        input  op_ready, movement, rotate, rot_addr, next_top,
        input  depth, fault, fault_code, stk_reset
    );

    modport slave (
        input  op_valid, op_code, op_n, op_data,
        input  stk_top, stk_second, stk_third, stk_rot_val,
        input  fault_ack,
        output op_ready, movement, rotate, rot_addr, next_top,
        output depth, fault, fault_code, stk_reset
    );

endinterface

// File: rtl/dstack_ctrl.sv
// ---------------------------------------------------------------------------
// dstack_ctrl
// Sequencer between the core0 decode stage and the dstack. Each op accepted
// over the valid/ready handshake is checked against the committed depth
// count; legal ops load the dstack command registers (driven one cycle after
// the accept), DROPN is broken into pop2/pop steps, and any illegal,
// overflowing or underflowing op parks the controller in FAULT until
// software acknowledges it.
// Ports
//   clk    : clock
//   reset  : asynchronous active-low reset
//   bus    : dstack_ctrl_if.slave (op handshake, dstack command/readback,
//            depth, fault report and fault_ack, stk_reset)
// ---------------------------------------------------------------------------
module dstack_ctrl #(
    parameter int DEPTH_MAG = 7,
    parameter int DEPTH     = 1 << DEPTH_MAG,
    parameter int WIDTH     = 32
) (
    input  logic          clk,
    input  logic          reset,
    dstack_ctrl_if.slave  bus
);

    // Depth is DEPTH_MAG+1 bits; comparisons against the 6-bit op_n are done
    // in a common width wide enough for both, so nothing truncates or wraps.
    localparam int DW = DEPTH_MAG + 1;
    localparam int CW = ((DW > 6) ? DW : 6) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_POP2  = 3'b011;
    localparam logic [2:0] OP_COPY  = 3'b100;
    localparam logic [2:0] OP_ROT   = 3'b101;
    localparam logic [2:0] OP_DROPN = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    localparam logic [1:0] MV_HOLD = 2'b00;
    localparam logic [1:0] MV_PUSH = 2'b01;
    localparam logic [1:0] MV_POP  = 2'b10;
    localparam logic [1:0] MV_POP2 = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DROP,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        SEL_KEEP,
        SEL_IMM,
        SEL_SEC,
        SEL_THR,
        SEL_ROT
    } topsel_t;

    state_t           r_state,      w_state_nxt;
    logic [DW-1:0]    r_depth,      w_depth_nxt;
    logic [DW-1:0]    r_rem,        w_rem_nxt;
    logic [1:0]       r_movement,   w_movement_nxt;
    logic             r_rotate,     w_rotate_nxt;
    logic [5:0]       r_rot_addr,   w_rot_addr_nxt;
    topsel_t          r_top_sel,    w_top_sel_nxt;
    logic [WIDTH-1:0] r_imm,        w_imm_nxt;
    logic             r_fault,      w_fault_nxt;
    logic [1:0]       r_fault_code, w_fault_code_nxt;
    logic             r_stk_reset,  w_stk_reset_nxt;
    logic             w_op_ready;
    logic [WIDTH-1:0] w_next_top;
    logic [CW-1:0]    w_d;
    logic [CW-1:0]    w_n;
    logic [1:0]       w_err;

    assign w_d = CW'(r_depth);
    assign w_n = CW'(bus.op_n);

    // Classify the presented op against the depth before it executes.
    // COPY tests the overflow rule first so overflow wins when both apply.
    always_comb begin
        w_err = ERR_NONE;
        case (bus.op_code)
            OP_NOP:   w_err = ERR_NONE;
            OP_PUSH:  if (w_d >= DEPTH_C) w_err = ERR_OVF;
            OP_POP:   if (w_d < CW'(1)) w_err = ERR_UNF;
            OP_POP2:  if (w_d < CW'(2)) w_err = ERR_UNF;
            OP_COPY: begin
                if (w_d >= DEPTH_C)  w_err = ERR_OVF;
                else if (w_n >= w_d) w_err = ERR_UNF;
            end
            OP_ROT:   if ((w_n == '0) || (w_n >= w_d)) w_err = ERR_UNF;
            OP_DROPN: if (w_n > w_d) w_err = ERR_UNF;
            OP_ILL:   w_err = ERR_ILL;
            default:  w_err = ERR_ILL;
        endcase
    end

    // Next-state and next-command logic. Command registers fall back to
    // hold/KEEP every cycle unless something is issued; rot_addr and the
    // immediate only change when an op actually uses them.
    always_comb begin
        w_state_nxt      = r_state;
        w_depth_nxt      = r_depth;
        w_rem_nxt        = r_rem;
        w_movement_nxt   = MV_HOLD;
        w_rotate_nxt     = 1'b0;
        w_rot_addr_nxt   = r_rot_addr;
        w_top_sel_nxt    = SEL_KEEP;
        w_imm_nxt        = r_imm;
        w_fault_nxt      = r_fault;
        w_fault_code_nxt = r_fault_code;
        w_stk_reset_nxt  = 1'b0;
        w_op_ready       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_op_ready = 1'b1;
                if (bus.op_valid) begin
                    if (w_err != ERR_NONE) begin
                        w_state_nxt      = S_FAULT;
                        w_fault_nxt      = 1'b1;
                        w_fault_code_nxt = w_err;
                    end else begin
                        case (bus.op_code)
                            OP_PUSH: begin
                                w_movement_nxt = MV_PUSH;
                                w_top_sel_nxt  = SEL_IMM;
                                w_imm_nxt      = bus.op_data;
                                w_depth_nxt    = DW'(w_d + CW'(1));
                            end
                            OP_POP: begin
                                w_movement_nxt = MV_POP;
                                w_top_sel_nxt  = SEL_SEC;
                                w_depth_nxt    = DW'(w_d - CW'(1));
                            end
                            OP_POP2: begin
                                w_movement_nxt = MV_POP2;
                                w_top_sel_nxt  = SEL_THR;
                                w_depth_nxt    = DW'(w_d - CW'(2));
                            end
                            OP_COPY: begin
                                w_movement_nxt = MV_PUSH;
                                w_top_sel_nxt  = SEL_ROT;
                                w_rot_addr_nxt = bus.op_n;
                                w_depth_nxt    = DW'(w_d + CW'(1));
                            end
                            OP_ROT: begin
                                w_rotate_nxt   = 1'b1;
                                w_top_sel_nxt  = SEL_ROT;
                                w_rot_addr_nxt = bus.op_n;
                            end
                            OP_DROPN: begin
                                // The whole drop is committed now; the first
                                // step issues from this edge and DROP covers
                                // whatever remains.
                                if (w_n != '0) begin
                                    w_depth_nxt = DW'(w_d - w_n);
                                    if (w_n >= CW'(2)) begin
                                        w_movement_nxt = MV_POP2;
                                        w_top_sel_nxt  = SEL_THR;
                                        w_rem_nxt      = DW'(w_n - CW'(2));
                                    end else begin
                                        w_movement_nxt = MV_POP;
                                        w_top_sel_nxt  = SEL_SEC;
                                        w_rem_nxt      = DW'(w_n - CW'(1));
                                    end
                                    if (w_rem_nxt != '0) w_state_nxt = S_DROP;
                                end
                            end
                            default: begin
                                w_movement_nxt = MV_HOLD;
                            end
                        endcase
                    end
                end
            end

            S_DROP: begin
                if (r_rem >= DW'(2)) begin
                    w_movement_nxt = MV_POP2;
                    w_top_sel_nxt  = SEL_THR;
                    w_rem_nxt      = r_rem - DW'(2);
                end else begin
                    w_movement_nxt = MV_POP;
                    w_top_sel_nxt  = SEL_SEC;
                    w_rem_nxt      = r_rem - DW'(1);
                end
                if (w_rem_nxt == '0) w_state_nxt = S_IDLE;
            end

            S_FAULT: begin
                // The acknowledge also empties the dstack, so depth restarts
                // at zero alongside a one-cycle stk_reset pulse.
                if (bus.fault_ack) begin
                    w_state_nxt      = S_IDLE;
                    w_depth_nxt      = '0;
                    w_rem_nxt        = '0;
                    w_fault_nxt      = 1'b0;
                    w_fault_code_nxt = ERR_NONE;
                    w_stk_reset_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and command registers. stk_reset comes out of reset high and
    // drops on the first edge after reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_depth      <= '0;
            r_rem        <= '0;
            r_movement   <= MV_HOLD;
            r_rotate     <= 1'b0;
            r_rot_addr   <= '0;
            r_top_sel    <= SEL_KEEP;
            r_imm        <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= ERR_NONE;
            r_stk_reset  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_depth      <= w_depth_nxt;
            r_rem        <= w_rem_nxt;
            r_movement   <= w_movement_nxt;
            r_rotate     <= w_rotate_nxt;
            r_rot_addr   <= w_rot_addr_nxt;
            r_top_sel    <= w_top_sel_nxt;
            r_imm        <= w_imm_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_stk_reset  <= w_stk_reset_nxt;
        end
    end

    // next_top follows the live dstack words, so it is steered by the
    // registered selector rather than registered itself.
    always_comb begin
        case (r_top_sel)
            SEL_IMM: w_next_top = r_imm;
            SEL_SEC: w_next_top = bus.stk_second;
            SEL_THR: w_next_top = bus.stk_third;
            SEL_ROT: w_next_top = bus.stk_rot_val;
            default: w_next_top = bus.stk_top;
        endcase
    end

    assign bus.op_ready   = w_op_ready;
    assign bus.movement   = r_movement;
    assign bus.rotate     = r_rotate;
    assign bus.rot_addr   = r_rot_addr;
    assign bus.next_top   = w_next_top;
    assign bus.depth      = r_depth;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;
    assign bus.stk_reset  = r_stk_reset;

endmodule

// File: tb/tb_dstack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dstack_ctrl
// Directed and randomized stimulus for dstack_ctrl. Expected outputs come
// from a behavioural model holding the element count, a fault flag and a
// queue of the pop steps a DROPN still owes.
// ---------------------------------------------------------------------------
module tb_dstack_ctrl;

    localparam int DEPTH_MAG = 7;
    localparam int DEPTH     = 1 << DEPTH_MAG;
    localparam int WIDTH     = 32;

    localparam int SEL_KEEP = 0;
    localparam int SEL_IMM  = 1;
    localparam int SEL_SEC  = 2;
    localparam int SEL_THR  = 3;
    localparam int SEL_ROT  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dstack_ctrl_if #(.DEPTH_MAG(DEPTH_MAG), .WIDTH(WIDTH)) bus ();

    dstack_ctrl #(
        .DEPTH_MAG (DEPTH_MAG),
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what the outputs should show after the most recent edge.
    int               expDepth;
    int               expMv;
    int               expRot;
    int               expRotAddr;
    int               expSel;
    int               expFault;
    int               expCode;
    int               expStkReset;
    logic [WIDTH-1:0] expImm;
    bit               mInFault;
    int               dropQ[$];

    // One immediate-assertion comparison; failures are counted and reported.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, using the dstack words
    // currently being driven for the combinational next_top.
    task automatic compareAll();
        logic [WIDTH-1:0] expTop;
        case (expSel)
            SEL_IMM: expTop = expImm;
            SEL_SEC: expTop = bus.stk_second;
            SEL_THR: expTop = bus.stk_third;
            SEL_ROT: expTop = bus.stk_rot_val;
            default: expTop = bus.stk_top;
        endcase
        checkOutput("op_ready",   64'(bus.op_ready),   64'(!mInFault && dropQ.size() == 0));
        checkOutput("movement",   64'(bus.movement),   64'(expMv));
        checkOutput("rotate",     64'(bus.rotate),     64'(expRot));
        checkOutput("next_top",   64'(bus.next_top),   64'(expTop));
        checkOutput("depth",      64'(bus.depth),      64'(expDepth));
        checkOutput("fault",      64'(bus.fault),      64'(expFault));
        checkOutput("fault_code", 64'(bus.fault_code), 64'(expCode));
        checkOutput("stk_reset",  64'(bus.stk_reset),  64'(expStkReset));
        if (expSel == SEL_ROT)
            checkOutput("rot_addr", 64'(bus.rot_addr), 64'(expRotAddr));
    endtask

    task automatic raiseFault(input int code);
        mInFault = 1'b1;
        expFault = 1;
        expCode  = code;
    endtask

    // Predict the effect of the coming clock edge from the stack rules.
    task automatic modelEdge(input bit valid, input int code, input int n,
                             input logic [WIDTH-1:0] data, input bit ack);
        int d;
        int rem;
        expMv       = 0;
        expRot      = 0;
        expSel      = SEL_KEEP;
        expStkReset = 0;
        if (mInFault) begin
            if (ack) begin
                mInFault    = 1'b0;
                expDepth    = 0;
                expFault    = 0;
                expCode     = 0;
                expStkReset = 1;
            end
        end else if (dropQ.size() > 0) begin
            expMv  = dropQ.pop_front();
            expSel = (expMv == 3) ? SEL_THR : SEL_SEC;
        end else if (valid) begin
            d = expDepth;
            case (code)
                0: ;
                1: if (d == DEPTH) raiseFault(1);
                   else begin expMv = 1; expSel = SEL_IMM; expImm = data; expDepth = d + 1; end
                2: if (d < 1) raiseFault(2);
                   else begin expMv = 2; expSel = SEL_SEC; expDepth = d - 1; end
                3: if (d < 2) raiseFault(2);
                   else begin expMv = 3; expSel = SEL_THR; expDepth = d - 2; end
                4: if (d == DEPTH) raiseFault(1);
                   else if (n >= d) raiseFault(2);
                   else begin expMv = 1; expSel = SEL_ROT; expRotAddr = n; expDepth = d + 1; end
                5: if (n < 1 || n >= d) raiseFault(2);
                   else begin expRot = 1; expSel = SEL_ROT; expRotAddr = n; end
                6: if (n > d) raiseFault(2);
                   else if (n > 0) begin
                       rem = n;
                       while (rem > 0) begin
                           if (rem >= 2) begin dropQ.push_back(3); rem -= 2; end
                           else begin dropQ.push_back(2); rem -= 1; end
                       end
                       expDepth = d - n;
                       expMv    = dropQ.pop_front();
                       expSel   = (expMv == 3) ? SEL_THR : SEL_SEC;
                   end
                default: raiseFault(3);
            endcase
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the outputs left
    // by the previous rising edge, then predict the next one.
    task automatic applyStimulus(input bit valid, input int code, input int n,
                                 input logic [WIDTH-1:0] data, input bit ack);
        @(negedge clk);
        bus.op_valid    = valid;
        bus.op_code     = code[2:0];
        bus.op_n        = n[5:0];
        bus.op_data     = data;
        bus.fault_ack   = ack;
        bus.stk_top     = $urandom;
        bus.stk_second  = $urandom;
        bus.stk_third   = $urandom;
        bus.stk_rot_val = $urandom;
        #1;
        compareAll();
        modelEdge(valid, code, n, data, ack);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 0, '0, 1'b0);
    endtask

    // Assert reset asynchronously, hold it, then release at a falling edge.
    task automatic holdReset(input int cycles);
        @(negedge clk);
        reset         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.fault_ack = 1'b0;
        #1;
        mInFault    = 1'b0;
        dropQ.delete();
        expDepth    = 0;
        expMv       = 0;
        expRot      = 0;
        expRotAddr  = 0;
        expSel      = SEL_KEEP;
        expFault    = 0;
        expCode     = 0;
        expStkReset = 1;
        expImm      = '0;
        compareAll();
        checkOutput("reset rot_addr", 64'(bus.rot_addr), 64'd0);
        repeat (cycles) begin
            @(negedge clk);
            #1;
            compareAll();
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        compareAll();
        modelEdge(1'b0, 0, 0, '0, 1'b0);
    endtask

    initial begin
        int r, code, n, lim;
        bit valid, ack;

        bus.op_valid    = 1'b0;
        bus.op_code     = '0;
        bus.op_n        = '0;
        bus.op_data     = '0;
        bus.fault_ack   = 1'b0;
        bus.stk_top     = '0;
        bus.stk_second  = '0;
        bus.stk_third   = '0;
        bus.stk_rot_val = '0;

        $display("[TB] reset");
        holdReset(2);

        $display("[TB] three back-to-back pushes");
        applyStimulus(1'b1, 1, 0, 32'hA, 1'b0);
        applyStimulus(1'b1, 1, 0, 32'hB, 1'b0);
        applyStimulus(1'b1, 1, 0, 32'hC, 1'b0);
        idleCycle();
        checkOutput("push next_top", 64'(bus.next_top), 64'hC);
        checkOutput("push depth",    64'(bus.depth),    64'd3);

        $display("[TB] rot n=2 at depth 3");
        applyStimulus(1'b1, 5, 2, '0, 1'b0);
        idleCycle();
        checkOutput("rot rotate",   64'(bus.rotate),   64'd1);
        checkOutput("rot rot_addr", 64'(bus.rot_addr), 64'd2);
        checkOutput("rot depth",    64'(bus.depth),    64'd3);

        $display("[TB] dropn n=5 at depth 7");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1, 0, $urandom, 1'b0);
        applyStimulus(1'b1, 6, 5, '0, 1'b0);
        applyStimulus(1'b1, 1, 0, 32'h55, 1'b0);
        checkOutput("dropn depth",   64'(bus.depth),    64'd2);
        checkOutput("dropn step1",   64'(bus.movement), 64'd3);
        applyStimulus(1'b1, 1, 0, 32'h66, 1'b0);
        checkOutput("dropn step2",   64'(bus.movement), 64'd3);
        idleCycle();
        checkOutput("dropn step3",   64'(bus.movement), 64'd2);
        checkOutput("dropn ready",   64'(bus.op_ready), 64'd1);

        $display("[TB] pop2 underflow and ack");
        applyStimulus(1'b1, 2, 0, '0, 1'b0);
        applyStimulus(1'b1, 3, 0, '0, 1'b0);
        applyStimulus(1'b1, 1, 0, 32'h77, 1'b0);
        checkOutput("unf fault_code", 64'(bus.fault_code), 64'd2);
        applyStimulus(1'b0, 0, 0, '0, 1'b1);
        idleCycle();
        checkOutput("ack stk_reset", 64'(bus.stk_reset), 64'd1);
        checkOutput("ack depth",     64'(bus.depth),     64'd0);
        applyStimulus(1'b0, 0, 0, '0, 1'b1);
        idleCycle();

        $display("[TB] illegal op at depth 0");
        applyStimulus(1'b1, 7, 0, '0, 1'b0);
        idleCycle();
        checkOutput("ill fault_code", 64'(bus.fault_code), 64'd3);
        applyStimulus(1'b0, 0, 0, '0, 1'b1);
        idleCycle();

        $display("[TB] copy overflow at full depth");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1, 0, $urandom, 1'b0);
        applyStimulus(1'b1, 4, 0, '0, 1'b0);
        idleCycle();
        checkOutput("ovf fault_code", 64'(bus.fault_code), 64'd1);
        checkOutput("ovf depth",      64'(bus.depth),      64'(DEPTH));
        applyStimulus(1'b0, 0, 0, '0, 1'b1);
        idleCycle();

        $display("[TB] reset during dropn n=40");
        for (int i = 0; i < 45; i++) applyStimulus(1'b1, 1, 0, $urandom, 1'b0);
        applyStimulus(1'b1, 6, 40, '0, 1'b0);
        repeat (3) idleCycle();
        holdReset(1);
        checkOutput("abort depth", 64'(bus.depth), 64'd0);
        repeat (4) idleCycle();

        $display("[TB] randomized ops");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                holdReset(1);
            end else begin
                valid = ($urandom_range(0, 3) != 0);
                ack   = ($urandom_range(0, 3) == 0);
                r     = $urandom_range(0, 99);
                if      (r < 40) code = 1;
                else if (r < 55) code = 2;
                else if (r < 62) code = 3;
                else if (r < 72) code = 4;
                else if (r < 80) code = 5;
                else if (r < 88) code = 6;
                else if (r < 95) code = 0;
                else             code = 7;
                lim = (expDepth < 63) ? expDepth : 63;
                if ($urandom_range(0, 7) == 0) n = $urandom_range(0, 63);
                else                           n = $urandom_range(0, lim);
                applyStimulus(valid, code, n, $urandom, ack);
            end
        end
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
